// File: rtl/packet_mux_rr_if.sv
// Stream bundle for packet_mux_rr: N_CH input streams plus one output stream
// that also carries the source channel index.
interface packet_mux_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]        s_valid;
  logic [N_CH-1:0]        s_last;
  logic [N_CH*DATA_W-1:0] s_data;
  logic [N_CH-1:0]        s_ready;
  logic                   m_valid;
  logic                   m_last;
  logic [DATA_W-1:0]      m_data;
  logic [CH_W-1:0]        m_chan;
  logic                   m_ready;

  // slave: the multiplexer side
  modport slave (
    input  s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_last, m_data, m_chan
  );

  // master: sources and sink around the multiplexer
  modport master (
    output s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_data, m_chan
  );
endinterface

// File: rtl/packet_mux_rr.sv
// N-channel packet multiplexer: round-robin grant held for a whole packet,
// single registered output stage tagged with the source channel.
//
// state | meaning
// IDLE  | no grant; searching requests from ptr+1 upward
// BUSY  | grant locked to one channel until its last beat is accepted
module packet_mux_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  packet_mux_rr_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   pick;
  logic              pick_vld;
  logic [N_CH-1:0]   s_ready;
  logic              busy_rdy;
  logic              accept;

  logic              m_valid_q;
  logic              m_last_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CH_W-1:0]   m_chan_q;

  // output register empty or draining this cycle
  assign busy_rdy = (state_q == BUSY) && (!m_valid_q || bus.m_ready);
  assign accept   = busy_rdy && bus.s_valid[grant_q];

  // first requester after ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!pick_vld && bus.s_valid[(int'(ptr_q) + i) % N_CH]) begin
        pick_vld = 1'b1;
        pick     = CH_W'((int'(ptr_q) + i) % N_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= CH_W'(N_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && bus.s_last[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready never looks at s_valid, only at grant and the output register
  always_comb begin
    s_ready = '0;
    if (state_q == BUSY) begin
      s_ready[grant_q] = busy_rdy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_last_q  <= bus.s_last[grant_q];
      m_data_q  <= bus.s_data[grant_q*DATA_W +: DATA_W];
      m_chan_q  <= grant_q;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_chan  = m_chan_q;

endmodule

// File: tb/tb_packet_mux_rr.sv
// Directed bench for packet_mux_rr: queue-driven sources, capturing sink,
// hand-computed expected beat sequences.
module tb_packet_mux_rr;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  packet_mux_rr_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  packet_mux_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int ch;
    int last;
    int data;
    int cyc;
  } beat_t;

  logic [8:0]      q [N_CH][$];
  logic [N_CH-1:0] gate;
  logic            mr;
  beat_t           cap [$];
  int              cyc;
  int              checks;
  int              failures;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [N_CH-1:0]        v;
    logic [N_CH-1:0]        l;
    logic [N_CH*DATA_W-1:0] d;
    logic [8:0]             f;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (q[i].size() > 0) begin
        f = q[i][0];
        v[i] = !gate[i];
        l[i] = f[8];
        d[i*DATA_W +: DATA_W] = f[7:0];
      end
    end
    bus.s_valid = v;
    bus.s_last  = l;
    bus.s_data  = d;
    bus.m_ready = mr;
  endtask

  // sample pre-edge handshakes, advance one clock, then update sources
  task automatic cycle();
    logic [N_CH-1:0] fire;
    beat_t b;
    fire = bus.s_valid & bus.s_ready;
    check_val("sready_onehot", 32'($countones(bus.s_ready) <= 1), 32'd1);
    if (bus.m_valid && bus.m_ready) begin
      b.ch   = int'(bus.m_chan);
      b.last = int'(bus.m_last);
      b.data = int'(bus.m_data);
      b.cyc  = cyc;
      cap.push_back(b);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_CH; i++)
      if (fire[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic run(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (cap.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check_val(tag, cap.size(), n);
  endtask

  task automatic load_pkt(input int ch, input int n, input int base);
    for (int k = 0; k < n; k++)
      q[ch].push_back({(k == n - 1), 8'(base + k)});
  endtask

  task automatic check_beat(input int i, input int ch, input int last, input int data);
    if (i < cap.size()) begin
      check_val($sformatf("beat%0d_chan", i), cap[i].ch, ch);
      check_val($sformatf("beat%0d_last", i), cap[i].last, last);
      check_val($sformatf("beat%0d_data", i), cap[i].data, data);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N_CH; i++) q[i].delete();
    gate = '0;
    mr   = 1'b1;
    cap.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int ch = 0; ch < N_CH; ch++) load_pkt(ch, 3, ch * 16);
    drive();
    #1;
    run(24, 200, "fair_beats");
    for (int i = 0; i < 24; i++)
      check_beat(i, (i / 3) % 4, (i % 3 == 2) ? 1 : 0, ((i / 3) % 4) * 16 + (i % 3));
    if (cap.size() >= 13) begin
      check_val("fair_in_pkt_gap", cap[1].cyc - cap[0].cyc, 1);
      check_val("fair_bubble", cap[3].cyc - cap[2].cyc, 2);
      check_val("fair_4pkt_cycles", cap[12].cyc - cap[0].cyc, 16);
    end
  endtask

  task automatic test_lock();
    int exp_ch [6];
    int exp_d  [6];
    int exp_l  [6];
    exp_ch = '{2, 2, 2, 2, 0, 0};
    exp_d  = '{'h20, 'h21, 'h22, 'h23, 'h00, 'h01};
    exp_l  = '{0, 0, 0, 1, 0, 1};
    do_reset();
    load_pkt(2, 4, 'h20);
    drive();
    #1;
    cycle();
    load_pkt(0, 2, 'h00);
    drive();
    #1;
    cycle();
    gate[2] = 1'b1;
    drive();
    #1;
    cycle();
    cycle();
    gate[2] = 1'b0;
    drive();
    #1;
    run(6, 60, "lock_beats");
    for (int i = 0; i < 6; i++) check_beat(i, exp_ch[i], exp_l[i], exp_d[i]);
  endtask

  task automatic test_backpressure();
    logic [11:0] pat;
    logic        stalled;
    logic [7:0]  h_data;
    logic        h_last;
    logic [1:0]  h_chan;
    int          k;
    pat     = 12'b101001101001;
    stalled = 1'b0;
    h_data  = '0;
    h_last  = 1'b0;
    h_chan  = '0;
    k       = 0;
    do_reset();
    load_pkt(1, 5, 'h10);
    while (cap.size() < 5 && k < 80) begin
      mr = pat[k % 12];
      drive();
      #1;
      if (stalled) begin
        check_val("bp_hold_valid", bus.m_valid, 1);
        check_val("bp_hold_data", bus.m_data, h_data);
        check_val("bp_hold_last", bus.m_last, h_last);
        check_val("bp_hold_chan", bus.m_chan, h_chan);
      end
      stalled = bus.m_valid && !bus.m_ready;
      if (stalled) begin
        check_val("bp_sready_low", bus.s_ready, 0);
        h_data = bus.m_data;
        h_last = bus.m_last;
        h_chan = bus.m_chan;
      end
      cycle();
      k++;
    end
    check_val("bp_beats", cap.size(), 5);
    for (int i = 0; i < 5; i++) check_beat(i, 1, (i == 4) ? 1 : 0, 'h10 + i);
    mr = 1'b1;
    drive();
    #1;
  endtask

  task automatic test_single_beat();
    int exp_ch [4];
    int exp_d  [4];
    exp_ch = '{1, 3, 1, 3};
    exp_d  = '{'hA1, 'hB1, 'hA2, 'hB2};
    do_reset();
    load_pkt(1, 1, 'hA1);
    load_pkt(3, 1, 'hB1);
    load_pkt(1, 1, 'hA2);
    load_pkt(3, 1, 'hB2);
    drive();
    #1;
    run(4, 40, "single_beats");
    for (int i = 0; i < 4; i++) check_beat(i, exp_ch[i], 1, exp_d[i]);
    if (cap.size() >= 4)
      for (int i = 0; i < 3; i++)
        check_val($sformatf("single_gap%0d", i), cap[i+1].cyc - cap[i].cyc, 2);
  endtask

  task automatic test_reset_mid_packet();
    int k;
    k = 0;
    do_reset();
    load_pkt(1, 4, 'h40);
    drive();
    #1;
    while (q[1].size() > 2 && k < 20) begin
      cycle();
      k++;
    end
    check_val("rst_pre_mvalid", bus.m_valid, 1);
    check_val("rst_pre_mchan", bus.m_chan, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_mvalid", bus.m_valid, 0);
    check_val("rst_async_sready", bus.s_ready, 0);
    check_val("rst_async_mchan", bus.m_chan, 0);
    for (int i = 0; i < N_CH; i++) q[i].delete();
    cap.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    load_pkt(1, 1, 'h51);
    load_pkt(3, 1, 'h53);
    drive();
    #1;
    run(2, 20, "rst_after_beats");
    check_beat(0, 1, 1, 'h51);
    check_beat(1, 3, 1, 'h53);
    repeat (4) cycle();
    check_val("rst_no_resume", cap.size(), 2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    gate     = '0;
    mr       = 1'b1;
    drive();
    #1;
    rst_n = 1'b0;
    #1;
    check_val("reset_mvalid", bus.m_valid, 0);
    check_val("reset_mlast", bus.m_last, 0);
    check_val("reset_mdata", bus.m_data, 0);
    check_val("reset_mchan", bus.m_chan, 0);
    check_val("reset_sready", bus.s_ready, 0);

    test_fairness();
    test_lock();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
